// File: rtl/johnson_phase_decoder.sv
// Johnson (twisted-ring) counter phase decoder with lock FSM and sequence monitor.
// Optional saturating error counter enabled by defining JDEC_ERR_CNT_EN.
module johnson_phase_decoder #(
    parameter  int N        = 4,
    parameter  int LOCK_CNT = 2,
    localparam int IDX_W    = $clog2(2*N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     jc_q,
    input  logic             clr_err,
    output logic [IDX_W-1:0] phase_idx,
    output logic [2*N-1:0]   phase_onehot,
    output logic             valid,
    output logic             locked,
    output logic             wrap_pulse,
    output logic             illegal_err,
    output logic             seq_err,
    output logic             err_sticky,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {UNLOCK, ACQ, LOCKED} state_t;

    localparam logic [N-1:0]     ONE_N    = 1;
    localparam logic [IDX_W-1:0] ONE_I    = 1;
    localparam logic [IDX_W-1:0] LAST_PH  = IDX_W'(2*N-1);
    localparam logic [3:0]       LOCK_THR = 4'(LOCK_CNT);

    state_t             state_q, state_d;
    logic [N-1:0]       samp_q;
    logic [IDX_W-1:0]   prev_q, prev_d;
    logic [3:0]         gcnt_q, gcnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [2*N-1:0]     onehot_q, onehot_d;
    logic               valid_q, valid_d;
    logic               locked_q, locked_d;
    logic               wrap_q, wrap_d;
    logic               ill_q, ill_d;
    logic               seq_q, seq_d;
    logic               sticky_q, sticky_d;

    logic               legal;
    logic [IDX_W-1:0]   phase;
    logic [IDX_W-1:0]   succ;
    logic               hold, adv, good;
    logic [N-1:0]       inv, plus1, inv_plus1;
    int                 ones;

    // Legal states are a run of ones from the LSB (MSB clear) or from the MSB (MSB set).
    always_comb begin
        inv       = ~samp_q;
        plus1     = samp_q + ONE_N;
        inv_plus1 = inv + ONE_N;
        ones      = 0;
        for (int i = 0; i < N; i++) ones = ones + int'(samp_q[i]);
        if (samp_q[N-1]) begin
            legal = ((inv & inv_plus1) == '0);
            phase = IDX_W'(2*N - ones);
        end else begin
            legal = ((samp_q & plus1) == '0);
            phase = IDX_W'(ones);
        end
        succ = (prev_q == LAST_PH) ? '0 : prev_q + ONE_I;
        hold = legal && (phase == prev_q);
        adv  = legal && (phase == succ);
        good = hold || adv;
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        gcnt_d  = gcnt_q;
        wrap_d  = 1'b0;
        ill_d   = 1'b0;
        seq_d   = 1'b0;
        unique case (state_q)
            UNLOCK: begin
                if (legal) begin
                    prev_d  = phase;
                    gcnt_d  = '0;
                    state_d = ACQ;
                end
            end
            ACQ: begin
                if (!good) begin
                    state_d = UNLOCK;
                end else if (adv) begin
                    prev_d = phase;
                    gcnt_d = gcnt_q + 4'd1;
                    if (gcnt_q + 4'd1 == LOCK_THR) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (!legal) begin
                    ill_d   = 1'b1;
                    state_d = UNLOCK;
                end else if (!good) begin
                    seq_d   = 1'b1;
                    state_d = UNLOCK;
                end else begin
                    wrap_d = adv && (prev_q == LAST_PH);
                    prev_d = phase;
                end
            end
            default: state_d = UNLOCK;
        endcase

        locked_d = (state_d == LOCKED);
        valid_d  = locked_d && legal;
        idx_d    = valid_d ? phase : idx_q;
        onehot_d = '0;
        if (valid_d) onehot_d[phase] = 1'b1;

        // Clear is applied before a same-cycle error so the error is never lost.
        sticky_d = clr_err ? 1'b0 : sticky_q;
        if (ill_d || seq_d) sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= UNLOCK;
            samp_q   <= '0;
            prev_q   <= '0;
            gcnt_q   <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            wrap_q   <= 1'b0;
            ill_q    <= 1'b0;
            seq_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            samp_q   <= jc_q;
            prev_q   <= prev_d;
            gcnt_q   <= gcnt_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            wrap_q   <= wrap_d;
            ill_q    <= ill_d;
            seq_q    <= seq_d;
            sticky_q <= sticky_d;
        end
    end

`ifdef JDEC_ERR_CNT_EN
    logic [7:0] ecnt_q, ecnt_d;

    always_comb begin
        ecnt_d = clr_err ? 8'd0 : ecnt_q;
        if ((ill_d || seq_d) && ecnt_d != 8'hFF) ecnt_d = ecnt_d + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt_q <= '0;
        else        ecnt_q <= ecnt_d;
    end

    assign err_cnt = ecnt_q;
`else
    assign err_cnt = '0;
`endif

    assign phase_idx    = idx_q;
    assign phase_onehot = onehot_q;
    assign valid        = valid_q;
    assign locked       = locked_q;
    assign wrap_pulse   = wrap_q;
    assign illegal_err  = ill_q;
    assign seq_err      = seq_q;
    assign err_sticky   = sticky_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Self-checking bench for johnson_phase_decoder (N=4, LOCK_CNT=2): vector table,
// hand-written corner sequences and randomized traffic against a reference model.
module tb_johnson_phase_decoder;

    localparam int N  = 4;
    localparam int NP = 2*N;
    localparam int LK = 2;
`ifdef JDEC_ERR_CNT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    typedef struct packed {
        logic       locked;
        logic       valid;
        logic [2:0] idx;
        logic [7:0] oh;
        logic       wrap;
        logic       ill;
        logic       seq;
        logic       sticky;
        logic [7:0] cnt;
    } obs_t;

    typedef struct {
        logic [3:0] jc;
        logic       clr;
        obs_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] jc_q = '0;
    logic       clr_err = 1'b0;
    logic [2:0] phase_idx;
    logic [7:0] phase_onehot;
    logic       valid, locked, wrap_pulse, illegal_err, seq_err, err_sticky;
    logic [7:0] err_cnt;

    johnson_phase_decoder #(.N(N), .LOCK_CNT(LK)) dut (
        .clk(clk), .rst_n(rst_n), .jc_q(jc_q), .clr_err(clr_err),
        .phase_idx(phase_idx), .phase_onehot(phase_onehot), .valid(valid),
        .locked(locked), .wrap_pulse(wrap_pulse), .illegal_err(illegal_err),
        .seq_err(seq_err), .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: phases found by searching the list of counter states.
    int         m_st, m_prev, m_gc;
    obs_t       m_obs;
    logic [3:0] pend;
    obs_t       got;

    function automatic logic [3:0] jstate(input int p);
        int v;
        if (p <= N) v = (1 << p) - 1;
        else        v = ((1 << N) - 1) & ~((1 << (p - N)) - 1);
        return 4'(v);
    endfunction

    function automatic obs_t mk(input bit l, v, input int idx, input int oh,
                                input bit w, i, s, st, input int c);
        obs_t o;
        o.locked = l; o.valid = v; o.idx = 3'(idx); o.oh = 8'(oh);
        o.wrap = w; o.ill = i; o.seq = s; o.sticky = st; o.cnt = 8'(c);
        return o;
    endfunction

    function automatic obs_t sample();
        return {locked, valid, phase_idx, phase_onehot, wrap_pulse,
                illegal_err, seq_err, err_sticky, err_cnt};
    endfunction

    task automatic model_reset();
        m_st = 0; m_prev = 0; m_gc = 0; m_obs = '0; pend = '0;
    endtask

    task automatic model_proc(input logic [3:0] v, input bit clr);
        int ph; bit lg, gd, adv; int ns;
        lg = 0; ph = 0;
        for (int p = 0; p < NP; p++) if (jstate(p) == v) begin lg = 1; ph = p; end
        adv = lg && (ph == (m_prev + 1) % NP);
        gd  = lg && (ph == m_prev || adv);
        ns = m_st;
        m_obs.wrap = 0; m_obs.ill = 0; m_obs.seq = 0;
        case (m_st)
            0: if (lg) begin m_prev = ph; m_gc = 0; ns = 1; end
            1: if (!gd) ns = 0;
               else if (adv) begin
                   m_prev = ph; m_gc++;
                   if (m_gc == LK) ns = 2;
               end
            default:
               if (!lg) begin m_obs.ill = 1; ns = 0; end
               else if (!gd) begin m_obs.seq = 1; ns = 0; end
               else begin m_obs.wrap = adv && (m_prev == NP-1); m_prev = ph; end
        endcase
        m_st = ns;
        m_obs.locked = (ns == 2);
        m_obs.valid  = m_obs.locked && lg;
        if (m_obs.valid) m_obs.idx = 3'(ph);
        m_obs.oh = m_obs.valid ? 8'(1 << ph) : 8'h00;
        if (clr) begin m_obs.sticky = 0; m_obs.cnt = 0; end
        if (m_obs.ill || m_obs.seq) begin
            m_obs.sticky = 1;
            if (CE && m_obs.cnt != 8'hFF) m_obs.cnt = m_obs.cnt + 8'd1;
        end
    endtask

    task automatic step(input logic [3:0] v, input bit c);
        jc_q = v; clr_err = c;
        @(posedge clk);
        model_proc(pend, c);
        pend = v;
        #1;
        got = sample();
    endtask

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; jc_q = '0; clr_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic mstep(input string name, input logic [3:0] v, input bit c);
        step(v, c);
        check(name, got, m_obs);
    endtask

    vec_t tbl[17];

    initial begin
        int c1, dp, r;
        logic [3:0] v;
        c1 = CE ? 1 : 0;
        //                  jc       clr   l v idx oh    w i s st cnt
        tbl[0]  = '{4'b0000, 0, mk(0,0,0,8'h00,0,0,0,0,0)};
        tbl[1]  = '{4'b0001, 0, mk(0,0,0,8'h00,0,0,0,0,0)};
        tbl[2]  = '{4'b0011, 0, mk(0,0,0,8'h00,0,0,0,0,0)};
        tbl[3]  = '{4'b0111, 0, mk(1,1,2,8'h04,0,0,0,0,0)};
        tbl[4]  = '{4'b1111, 0, mk(1,1,3,8'h08,0,0,0,0,0)};
        tbl[5]  = '{4'b1110, 0, mk(1,1,4,8'h10,0,0,0,0,0)};
        tbl[6]  = '{4'b1100, 0, mk(1,1,5,8'h20,0,0,0,0,0)};
        tbl[7]  = '{4'b1000, 0, mk(1,1,6,8'h40,0,0,0,0,0)};
        tbl[8]  = '{4'b0000, 0, mk(1,1,7,8'h80,0,0,0,0,0)};
        tbl[9]  = '{4'b0001, 0, mk(1,1,0,8'h01,1,0,0,0,0)};
        tbl[10] = '{4'b0011, 0, mk(1,1,1,8'h02,0,0,0,0,0)};
        tbl[11] = '{4'b0101, 0, mk(1,1,2,8'h04,0,0,0,0,0)};
        tbl[12] = '{4'b0111, 0, mk(0,0,2,8'h00,0,1,0,1,c1)};
        tbl[13] = '{4'b1111, 0, mk(0,0,2,8'h00,0,0,0,1,c1)};
        tbl[14] = '{4'b1110, 0, mk(0,0,2,8'h00,0,0,0,1,c1)};
        tbl[15] = '{4'b1110, 0, mk(1,1,5,8'h20,0,0,0,1,c1)};
        tbl[16] = '{4'b1110, 0, mk(1,1,5,8'h20,0,0,0,1,c1)};

        rst_n = 0;
        #2;
        check("reset_state", sample(), '0);
        do_reset();

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].jc, tbl[i].clr);
            check($sformatf("table[%0d]", i), got, tbl[i].exp);
        end

        // Hold at phase 3 for several cycles, then skip to phase 6.
        do_reset();
        foreach (tbl[i]) if (i < 4) mstep("hs_lock", tbl[i].jc, 0);
        repeat (3) mstep("hs_hold", 4'b0111, 0);
        mstep("hs_hold", 4'b1100, 0);
        check_bit("hs_no_err_in_hold", got.seq, 1'b0);
        mstep("hs_skip", 4'b1100, 0);
        check_bit("hs_seq_err", got.seq, 1'b1);
        check_bit("hs_unlocked", got.locked, 1'b0);

        // Five errors, then a sixth colliding with clr_err.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            mstep("cc_acq", 4'b0000, 0);
            mstep("cc_acq", 4'b0001, 0);
            mstep("cc_acq", 4'b0011, 0);
            mstep("cc_bad", 4'b0101, 0);
        end
        check_bit("cc_cnt5_prior", got.cnt == 8'(CE ? 5 : 0), 1'b1);
        mstep("cc_collide", 4'b0000, 1);
        check_bit("cc_collide_ill", got.ill, 1'b1);
        check("cc_collide_val", got, mk(0,0,2,8'h00,0,1,0,1,c1));
        mstep("cc_clear", 4'b0000, 1);
        check_bit("cc_clear_sticky", got.sticky, 1'b0);
        check_bit("cc_clear_cnt", got.cnt == 8'd0, 1'b1);

        // Asynchronous reset between edges while locked.
        do_reset();
        for (int p = 0; p < 6; p++) mstep("ar_lock", jstate(p), 0);
        check_bit("ar_locked_before", got.locked, 1'b1);
        #3;
        rst_n = 0;
        #1;
        check("ar_async_zero", sample(), '0);
        model_reset();
        #2;
        rst_n = 1;
        for (int p = 1; p < 4; p++) begin
            mstep("ar_relock", jstate(p), 0);
            if (p < 3) check_bit("ar_not_yet_locked", got.locked, 1'b0);
        end
        mstep("ar_relock", jstate(4), 0);
        check_bit("ar_relocked", got.locked, 1'b1);

        // Randomized traffic, biased toward legal advances.
        do_reset();
        dp = 0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(99);
            if (r < 70)      dp = (dp + 1) % NP;
            else if (r < 85) dp = dp;
            else if (r < 95) dp = $urandom_range(NP-1);
            v = jstate(dp);
            if (r >= 95) v = 4'($urandom_range(15));
            mstep("random", v, $urandom_range(19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
